// File: rtl/mkio_loader_pkg.sv
// mkio_loader_pkg: shared types and constants for the DEV4 block loader.
// MKIO_LOADER_WORDCNT_EN reserves address 31 for the per-block word count.
package mkio_loader_pkg;
  localparam int ADDR_W  = 5;
  localparam int WORD_W  = 16;
  localparam int ENTRY_W = WORD_W + 1;
  localparam logic [ADDR_W-1:0] CNT_ADDR = 5'd31;
`ifdef MKIO_LOADER_WORDCNT_EN
  localparam logic [ADDR_W:0] LAST_DATA = 6'd30;
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, CSETUP, CSTROBE, CHOLD
  } loader_state_t;
`else
  localparam logic [ADDR_W:0] LAST_DATA = 6'd31;
  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, HOLD
  } loader_state_t;
`endif
endpackage

// File: rtl/mkio_loader_fifo.sv
// mkio_loader_fifo: synchronous FIFO of {last, data} entries.
// Registered count, full and empty flags; full is held during reset.
module mkio_loader_fifo
  import mkio_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, cnt_n;
  logic do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    cnt_n = count;
    if (do_push && !do_pop)
      cnt_n = count + (AW+1)'(1);
    else if (!do_push && do_pop)
      cnt_n = count - (AW+1)'(1);
  end

  // full reads high in reset so upstream sees s_ready low
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_n;
      full  <= (cnt_n == FULL_CNT);
      empty <= (cnt_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/mkio_dev4_loader.sv
// mkio_dev4_loader: buffers a block stream and writes it into MKIO DEV4 memory.
// MKIO_LOADER_WORDCNT_EN appends the block word count at address 31.
module mkio_dev4_loader
  import mkio_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] addr_wr_dev4,
  output logic [WORD_W-1:0] in_data_dev4,
  output logic              clk_wr_dev4,
  output logic              we_dev4,
  input  logic              busy_dev4,
  output logic              block_done,
  output logic              overflow,
  input  logic              ovf_clr
);
  logic f_full, f_empty, push, pop;
  logic [ENTRY_W-1:0] head;

  loader_state_t state, state_n;
  logic [ADDR_W:0] wptr, wptr_n, wcnt, wcnt_n;
  logic cur_last, last_n;
  logic [ADDR_W-1:0] addr_n;
  logic [WORD_W-1:0] data_n;
  logic clkw_n, we_n, done_n, set_ovf, fetch, finish;
`ifdef MKIO_LOADER_WORDCNT_EN
  logic pend, pend_n;
`endif

  assign s_ready = !f_full;
  assign push    = s_valid && !f_full;

  mkio_loader_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata({s_last, s_data}),
    .pop  (pop),
    .rdata(head),
    .full (f_full),
    .empty(f_empty)
  );

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    wcnt_n  = wcnt;
    last_n  = cur_last;
    addr_n  = addr_wr_dev4;
    data_n  = in_data_dev4;
    clkw_n  = 1'b0;
    we_n    = we_dev4;
    done_n  = 1'b0;
    set_ovf = 1'b0;
    pop     = 1'b0;
    fetch   = 1'b0;
    finish  = 1'b0;
`ifdef MKIO_LOADER_WORDCNT_EN
    pend_n  = pend;
`endif
    unique case (state)
      IDLE: begin
        we_n = 1'b0;
`ifdef MKIO_LOADER_WORDCNT_EN
        finish = pend;
        fetch  = !pend;
`else
        fetch  = 1'b1;
`endif
      end
      SETUP: begin
        state_n = STROBE;
        clkw_n  = 1'b1;
      end
      STROBE: begin
        state_n = HOLD;
        wptr_n  = wptr + 6'd1;
        wcnt_n  = wcnt + 6'd1;
      end
      HOLD: begin
        state_n = IDLE;
        we_n    = 1'b0;
        finish  = cur_last;
        fetch   = !cur_last;
      end
`ifdef MKIO_LOADER_WORDCNT_EN
      CSETUP: begin
        state_n = CSTROBE;
        clkw_n  = 1'b1;
      end
      CSTROBE: state_n = CHOLD;
      CHOLD: begin
        state_n = IDLE;
        we_n    = 1'b0;
        done_n  = 1'b1;
        wptr_n  = '0;
        wcnt_n  = '0;
      end
`endif
      default: state_n = IDLE;
    endcase

    // a popped word beyond the data area is dropped without a strobe
    if (fetch && !f_empty && !busy_dev4) begin
      pop    = 1'b1;
      last_n = head[WORD_W];
      if (wptr > LAST_DATA) begin
        set_ovf = 1'b1;
        finish  = head[WORD_W];
      end else begin
        state_n = SETUP;
        addr_n  = wptr[ADDR_W-1:0];
        data_n  = head[WORD_W-1:0];
        we_n    = 1'b1;
      end
    end

    if (finish) begin
`ifdef MKIO_LOADER_WORDCNT_EN
      if (!busy_dev4) begin
        state_n = CSETUP;
        addr_n  = CNT_ADDR;
        data_n  = {10'd0, wcnt};
        we_n    = 1'b1;
        pend_n  = 1'b0;
      end else begin
        pend_n  = 1'b1;
      end
`else
      done_n = 1'b1;
      wptr_n = '0;
      wcnt_n = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wptr         <= '0;
      wcnt         <= '0;
      cur_last     <= 1'b0;
      addr_wr_dev4 <= '0;
      in_data_dev4 <= '0;
      clk_wr_dev4  <= 1'b0;
      we_dev4      <= 1'b0;
      block_done   <= 1'b0;
      overflow     <= 1'b0;
`ifdef MKIO_LOADER_WORDCNT_EN
      pend         <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      wptr         <= wptr_n;
      wcnt         <= wcnt_n;
      cur_last     <= last_n;
      addr_wr_dev4 <= addr_n;
      in_data_dev4 <= data_n;
      clk_wr_dev4  <= clkw_n;
      we_dev4      <= we_n;
      block_done   <= done_n;
      overflow     <= set_ovf || (overflow && !ovf_clr);
`ifdef MKIO_LOADER_WORDCNT_EN
      pend         <= pend_n;
`endif
    end
  end
endmodule

// File: tb/tb_mkio_dev4_loader.sv
// tb_mkio_dev4_loader: randomized self-checking bench for the DEV4 loader.
// Expected DEV4 writes are derived from the pushed blocks, not from the RTL.
`timescale 1ns/1ps
module tb_mkio_dev4_loader;
`ifdef MKIO_LOADER_WORDCNT_EN
  localparam int LAST_D = 30;
  localparam int CNT_EN = 1;
`else
  localparam int LAST_D = 31;
  localparam int CNT_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic busy_dev4 = 1'b0;
  logic ovf_clr = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready, clk_wr_dev4, we_dev4, block_done, overflow;
  logic [4:0] addr_wr_dev4;
  logic [15:0] in_data_dev4;

  int checks = 0;
  int failures = 0;
  logic [20:0] exp_q[$];
  logic [20:0] mon_e;
  int rise_cyc[$];
  int blk_idx = 0;
  int exp_done = 0;
  int done_cnt = 0;
  int cyc = 0;
  int nrise = 0;
  bit exp_ovf = 0;
  bit rand_busy = 0;
  bit prev_clk = 0;

  always #5 clk = ~clk;

  mkio_dev4_loader #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .addr_wr_dev4(addr_wr_dev4),
    .in_data_dev4(in_data_dev4),
    .clk_wr_dev4 (clk_wr_dev4),
    .we_dev4     (we_dev4),
    .busy_dev4   (busy_dev4),
    .block_done  (block_done),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  // write monitor: every rising clk_wr_dev4 must match the next expected write
  initial forever begin
    @(negedge clk);
    cyc++;
    if (clk_wr_dev4 === 1'b1 && !prev_clk) begin
      nrise++;
      rise_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h", addr_wr_dev4, in_data_dev4);
      end else begin
        mon_e = exp_q.pop_front();
        if ({addr_wr_dev4, in_data_dev4} !== mon_e || we_dev4 !== 1'b1) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h we=%b want addr=%0d data=%h we=1",
                   addr_wr_dev4, in_data_dev4, we_dev4, mon_e[20:16], mon_e[15:0]);
        end
      end
    end
    if (clk_wr_dev4 === 1'b1 && prev_clk) begin
      checks++;
      failures++;
      $display("FAIL strobe_width clk_wr high=2+ cycles want=1 at addr=%0d", addr_wr_dev4);
    end
    if (block_done === 1'b1) done_cnt++;
    prev_clk = (clk_wr_dev4 === 1'b1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog sim_time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (rand_busy) busy_dev4 = ($urandom_range(0, 3) == 0);
  endtask

  task automatic model_accept(input logic [15:0] d, input logic l);
    int wr;
    if (blk_idx <= LAST_D) exp_q.push_back({5'(blk_idx), d});
    else exp_ovf = 1;
    blk_idx++;
    if (l) begin
      wr = (blk_idx < LAST_D + 1) ? blk_idx : LAST_D + 1;
      if (CNT_EN != 0) exp_q.push_back({5'd31, 16'(wr)});
      exp_done++;
      blk_idx = 0;
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (s_ready !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      checks++;
      failures++;
      $display("FAIL push_timeout s_ready=%b want=1 data=%h", s_ready, d);
      s_valid = 1'b0;
      return;
    end
    tick();
    s_valid = 1'b0;
    model_accept(d, l);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_cnt != exp_done) && n < 5000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || done_cnt != exp_done) begin
      failures++;
      $display("FAIL drain_%s pending=%0d done=%0d want pending=0 done=%0d",
               tag, exp_q.size(), done_cnt, exp_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({s_ready, we_dev4, clk_wr_dev4, block_done, overflow,
         addr_wr_dev4, in_data_dev4} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b we=%b clk=%b done=%b ovf=%b addr=%0d data=%h want all 0",
               s_ready, we_dev4, clk_wr_dev4, block_done, overflow, addr_wr_dev4, in_data_dev4);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b want=1", s_ready);
    end
  endtask

  task automatic test_single();
    push_word(16'hA5A5, 1'b1);
    checks++;
    if (we_dev4 !== 1'b0 || clk_wr_dev4 !== 1'b0) begin
      failures++;
      $display("FAIL e0_idle we=%b clk=%b want 0 0", we_dev4, clk_wr_dev4);
    end
    tick();
    checks++;
    if (we_dev4 !== 1'b1 || clk_wr_dev4 !== 1'b0 ||
        addr_wr_dev4 !== 5'd0 || in_data_dev4 !== 16'hA5A5) begin
      failures++;
      $display("FAIL setup we=%b clk=%b addr=%0d data=%h want 1 0 0 a5a5",
               we_dev4, clk_wr_dev4, addr_wr_dev4, in_data_dev4);
    end
    tick();
    checks++;
    if (clk_wr_dev4 !== 1'b1 || we_dev4 !== 1'b1) begin
      failures++;
      $display("FAIL strobe clk=%b we=%b want 1 1", clk_wr_dev4, we_dev4);
    end
    tick();
    checks++;
    if (clk_wr_dev4 !== 1'b0 || we_dev4 !== 1'b1 || block_done !== 1'b0) begin
      failures++;
      $display("FAIL hold clk=%b we=%b done=%b want 0 1 0", clk_wr_dev4, we_dev4, block_done);
    end
    tick();
`ifdef MKIO_LOADER_WORDCNT_EN
    checks++;
    if (we_dev4 !== 1'b1 || addr_wr_dev4 !== 5'd31 ||
        in_data_dev4 !== 16'd1 || block_done !== 1'b0) begin
      failures++;
      $display("FAIL cnt_setup we=%b addr=%0d data=%h done=%b want 1 31 0001 0",
               we_dev4, addr_wr_dev4, in_data_dev4, block_done);
    end
`else
    checks++;
    if (we_dev4 !== 1'b0 || block_done !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse we=%b done=%b want 0 1", we_dev4, block_done);
    end
`endif
    drain("single");
  endtask

  task automatic test_busy();
    int base, n;
    busy_dev4 = 1'b1;
    push_word(16'h0001, 1'b0);
    push_word(16'h0002, 1'b0);
    push_word(16'h0003, 1'b1);
    base = nrise;
    repeat (10) tick();
    checks++;
    if (nrise != base) begin
      failures++;
      $display("FAIL busy_gate writes=%0d want=0", nrise - base);
    end
    busy_dev4 = 1'b0;
    drain("busy");
    n = rise_cyc.size();
    checks++;
    if (rise_cyc[n-1] - rise_cyc[n-2] != 3 || rise_cyc[n-2] - rise_cyc[n-3] != 3) begin
      failures++;
      $display("FAIL b2b_spacing gaps=%0d,%0d want 3,3",
               rise_cyc[n-2] - rise_cyc[n-3], rise_cyc[n-1] - rise_cyc[n-2]);
    end
  endtask

  task automatic test_backpressure();
    busy_dev4 = 1'b1;
    for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i), 1'b0);
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_full got=%b want=0", s_ready);
    end
    s_valid = 1'b1;
    s_data = 16'h0108;
    s_last = 1'b0;
    repeat (4) tick();
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_held got=%b want=0", s_ready);
    end
    busy_dev4 = 1'b0;
    push_word(16'h0108, 1'b0);
    push_word(16'h0109, 1'b1);
    drain("backpressure");
  endtask

  task automatic test_overflow();
    int base;
    base = nrise;
    for (int i = 0; i < 34; i++) push_word(16'($urandom), i == 33);
    drain("overflow");
    checks++;
    if (nrise - base != LAST_D + 1 + CNT_EN) begin
      failures++;
      $display("FAIL ovf_writes got=%0d want=%0d", nrise - base, LAST_D + 1 + CNT_EN);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      failures++;
      $display("FAIL ovf_set got=%b want=%b", overflow, exp_ovf);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    exp_ovf = 0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr got=%b want=0", overflow);
    end
  endtask

  task automatic test_random();
    int len;
    rand_busy = 1;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        push_word(16'($urandom), i == len - 1);
      end
      drain("random");
      checks++;
      if (overflow !== exp_ovf) begin
        failures++;
        $display("FAIL rand_ovf blk=%0d len=%0d got=%b want=%b", b, len, overflow, exp_ovf);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      exp_ovf = 0;
    end
    rand_busy = 0;
    busy_dev4 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n, base;
    push_word(16'hC001, 1'b0);
    push_word(16'hC002, 1'b0);
    push_word(16'hC003, 1'b1);
    n = 0;
    while (clk_wr_dev4 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL mid_strobe_timeout clk=%b want=1", clk_wr_dev4);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (we_dev4 !== 1'b0 || clk_wr_dev4 !== 1'b0 ||
        s_ready !== 1'b0 || block_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid we=%b clk=%b rdy=%b done=%b want 0 0 0 0",
               we_dev4, clk_wr_dev4, s_ready, block_done);
    end
    exp_q.delete();
    blk_idx = 0;
    exp_done = done_cnt;
    exp_ovf = 0;
    reset = 1'b0;
    tick();
    base = nrise;
    repeat (8) tick();
    checks++;
    if (nrise != base) begin
      failures++;
      $display("FAIL fifo_flush writes=%0d want=0", nrise - base);
    end
    push_word(16'h5A5A, 1'b1);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy();
    test_backpressure();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
